// File: rtl/lfsr_pkg.sv
// ============================================================================
// Module   : lfsr_pkg
// Brief    : Sequencer state encoding and default LFSR core geometry shared by
//            the share controller, the LFSR core and its reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lfsr_pkg;

    typedef enum logic [1:0] {
        SEED    = 2'd0,
        IDLE    = 2'd1,
        STEP    = 2'd2,
        DELIVER = 2'd3
    } lfsr_state_t;

    localparam int          c_lfsr_nbits = 8;
    // x^8 + x^6 + x^5 + x^4 + 1, maximal length for 8 bits
    localparam logic [7:0]  c_lfsr_taps  = 8'hB8;

endpackage : lfsr_pkg

`default_nettype wire

// File: rtl/lfsr_share_ctrl_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first eligible requester found
//            scanning upward from last_grant+1, wrapping modulo NREQ.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic [IW-1:0]   last_grant,
    output logic            valid,
    output logic [IW-1:0]   grant_idx
);

    logic [NREQ-1:0] w_eligible;
    int              w_cand;

    assign w_eligible = req & ~mask;

    // NREQ need not be a power of two, so the wrap is an explicit compare
    always_comb begin
        valid     = 1'b0;
        grant_idx = '0;
        w_cand    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = int'(last_grant) + i;
            if (w_cand >= NREQ) begin
                w_cand = w_cand - NREQ;
            end
            if (!valid && w_eligible[w_cand[IW-1:0]]) begin
                valid     = 1'b1;
                grant_idx = w_cand[IW-1:0];
            end
        end
    end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/lfsr_share_ctrl.sv
// ============================================================================
// Module   : lfsr_share_ctrl
// Brief    : Seeds an external LFSR core and shares it round-robin between
//            NREQ requesters, advancing it STEPS times per delivered draw.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_share_ctrl
    import lfsr_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int NBITS       = c_lfsr_nbits,
    parameter int STEPS       = 8,
    parameter int SEED_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  ack,
    output logic [NBITS-1:0] rnd_data,
    input  logic             reseed,
    output logic             busy,
    output logic             lfsr_reset,
    output logic             lfsr_enable,
    input  logic             lfsr_ready,
    input  logic [NBITS-1:0] lfsr_value
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = $clog2(SEED_CYCLES + 1);
    localparam int TW = $clog2(STEPS + 1);

    localparam logic [SW-1:0] c_seed_max  = SW'(SEED_CYCLES);
    localparam logic [TW-1:0] c_step_last = TW'(STEPS - 1);
    localparam logic [IW-1:0] c_last_req  = IW'(NREQ - 1);

    lfsr_state_t    r_state;
    logic [SW-1:0]  r_seed_cnt;
    logic [TW-1:0]  r_step_cnt;
    logic [IW-1:0]  r_grant_idx;
    logic [IW-1:0]  r_last_grant;
    logic           r_reseed_pend;

    logic           w_arb_valid;
    logic [IW-1:0]  w_arb_idx;

    // Current ack masks its owner so a requester lagging one cycle on
    // dropping req is not granted a second draw
    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req        (req),
        .mask       (ack),
        .last_grant (r_last_grant),
        .valid      (w_arb_valid),
        .grant_idx  (w_arb_idx)
    );

    assign busy       = (r_state != IDLE);
    assign lfsr_reset = (r_state == SEED);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= SEED;
            r_seed_cnt    <= '0;
            r_step_cnt    <= '0;
            r_grant_idx   <= '0;
            r_last_grant  <= c_last_req;
            r_reseed_pend <= 1'b0;
            ack           <= '0;
            rnd_data      <= '0;
            lfsr_enable   <= 1'b0;
        end else begin
            ack <= '0;
            if (reseed) begin
                r_reseed_pend <= 1'b1;
            end

            case (r_state)
                SEED: begin
                    // A reseed while already seeding just restarts the count
                    r_reseed_pend <= 1'b0;
                    if (reseed) begin
                        r_seed_cnt <= '0;
                    end else begin
                        if (r_seed_cnt != c_seed_max) begin
                            r_seed_cnt <= r_seed_cnt + SW'(1);
                        end
                        if ((r_seed_cnt == c_seed_max) && lfsr_ready) begin
                            r_state <= IDLE;
                        end
                    end
                end

                IDLE: begin
                    if (r_reseed_pend) begin
                        r_state       <= SEED;
                        r_seed_cnt    <= '0;
                        r_reseed_pend <= 1'b0;
                    end else if (w_arb_valid) begin
                        r_grant_idx <= w_arb_idx;
                        r_step_cnt  <= '0;
                        lfsr_enable <= 1'b1;
                        r_state     <= STEP;
                    end
                end

                STEP: begin
                    if (r_step_cnt == c_step_last) begin
                        lfsr_enable <= 1'b0;
                        r_state     <= DELIVER;
                    end else begin
                        r_step_cnt <= r_step_cnt + TW'(1);
                    end
                end

                DELIVER: begin
                    rnd_data     <= lfsr_value;
                    ack          <= NREQ'(1) << r_grant_idx;
                    r_last_grant <= r_grant_idx;
                    r_state      <= IDLE;
                end

                default: begin
                    r_state     <= SEED;
                    r_seed_cnt  <= '0;
                    lfsr_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule : lfsr_share_ctrl

`default_nettype wire

// File: tb/tb_lfsr_share_ctrl.sv
// ============================================================================
// Module   : tb_lfsr_share_ctrl
// Brief    : Directed bench for lfsr_share_ctrl with a Fibonacci LFSR core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_share_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       reseed = 1'b0;
    logic [3:0] ack;
    logic [7:0] rnd_data;
    logic       busy;
    logic       lfsr_reset;
    logic       lfsr_enable;
    logic       lfsr_ready;
    logic [7:0] lfsr_value;

    logic [7:0] core = 8'h00;
    bit         stuck = 1'b0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    lfsr_share_ctrl #(
        .NREQ        (4),
        .NBITS       (8),
        .STEPS       (8),
        .SEED_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ack         (ack),
        .rnd_data    (rnd_data),
        .reseed      (reseed),
        .busy        (busy),
        .lfsr_reset  (lfsr_reset),
        .lfsr_enable (lfsr_enable),
        .lfsr_ready  (lfsr_ready),
        .lfsr_value  (lfsr_value)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // LFSR core: shifts in ones while held in reset, Fibonacci taps 8,6,5,4
    always @(posedge clk) begin
        if (lfsr_reset)
            core <= {core[6:0], 1'b1};
        else if (lfsr_enable)
            core <= {core[6:0], core[7] ^ core[5] ^ core[4] ^ core[3]};
    end
    assign lfsr_value = core;
    assign lfsr_ready = (core == 8'hFF) && !stuck;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic       reseed;
        logic [3:0] e_ack;
        logic       e_busy;
        logic       e_lrst;
        logic       e_len;
        logic       chk_data;
        logic [7:0] e_data;
    } vec_t;

    vec_t vt[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Returns positioned at the negedge of the ack cycle when found
    task automatic wait_ack(input int budget, output int idx, output int at,
                            output logic [7:0] data, output bit ok);
        ok = 1'b0; idx = -1; at = -1; data = 8'h00;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack != 4'b0000) begin
                ok = 1'b1; at = cyc; data = rnd_data;
                for (int j = 0; j < 4; j++) if (ack[j]) idx = j;
                chk("ack_onehot", 32'($countones(ack)), 32'd1);
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         idx, at, prev_at, prev_idx, tcyc, seeds, n_bad, n_ack;
        logic [7:0] data;
        bit         ok, found;
        int         exp_order[6] = '{0, 1, 2, 3, 0, 1};

        // ---- table: power-on seeding followed by a single draw for req[2]
        for (int k = 0; k < 22; k++)
            vt[k] = '{rst:1'b0, req:4'b0100, reseed:1'b0, e_ack:4'b0000, e_busy:1'b1,
                      e_lrst:1'b0, e_len:1'b0, chk_data:1'b0, e_data:8'h00};
        for (int k = 0; k <= 8; k++) vt[k].e_lrst = 1'b1;
        vt[0].chk_data = 1'b1;
        vt[9].e_busy   = 1'b0;
        for (int k = 10; k <= 17; k++) vt[k].e_len = 1'b1;
        vt[19].e_ack = 4'b0100; vt[19].e_busy = 1'b0; vt[19].chk_data = 1'b1; vt[19].e_data = 8'h0B;
        for (int k = 20; k <= 21; k++) begin
            vt[k].req = 4'b0000; vt[k].e_busy = 1'b0; vt[k].chk_data = 1'b1; vt[k].e_data = 8'h0B;
        end

        reset = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 22; k++) begin
            reset = vt[k].rst; req = vt[k].req; reseed = vt[k].reseed;
            @(negedge clk);
            chk($sformatf("vec%0d_ack", k), 32'(ack), 32'(vt[k].e_ack));
            chk($sformatf("vec%0d_busy", k), 32'(busy), 32'(vt[k].e_busy));
            chk($sformatf("vec%0d_lfsr_reset", k), 32'(lfsr_reset), 32'(vt[k].e_lrst));
            chk($sformatf("vec%0d_lfsr_enable", k), 32'(lfsr_enable), 32'(vt[k].e_len));
            if (vt[k].chk_data)
                chk($sformatf("vec%0d_rnd_data", k), 32'(rnd_data), 32'(vt[k].e_data));
            @(posedge clk); #1;
        end

        // ---- fairness with all four requesters held high
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req = 4'b1111;
        prev_at = 0; prev_idx = -1;
        for (int n = 0; n < 6; n++) begin
            wait_ack(60, idx, at, data, ok);
            chk($sformatf("fair%0d_seen", n), 32'(ok), 32'd1);
            if (!ok) break;
            chk($sformatf("fair%0d_idx", n), 32'(idx), 32'(exp_order[n]));
            if (n > 0) begin
                chk($sformatf("fair%0d_spacing", n), 32'(at - prev_at), 32'd10);
                chk($sformatf("fair%0d_repeat", n), 32'(idx == prev_idx), 32'd0);
            end
            if (n == 0) chk("fair0_data", 32'(data), 32'h0B);
            if (n == 1) chk("fair1_data", 32'(data), 32'hC6);
            prev_at = at; prev_idx = idx;
            @(posedge clk); #1;
        end
        req = 4'b0000;

        // ---- reseed pulse on the third STEP cycle
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        wait_idle(40, ok);
        chk("reseed_idle_seen", 32'(ok), 32'd1);
        tcyc = cyc;
        req = 4'b0001;
        repeat (3) begin @(posedge clk); #1; end
        chk("reseed_step3_enable", 32'(lfsr_enable), 32'd1);
        reseed = 1'b1;
        @(posedge clk); #1;
        reseed = 1'b0;
        wait_ack(20, idx, at, data, ok);
        chk("reseed_draw_seen", 32'(ok), 32'd1);
        chk("reseed_draw_idx", 32'(idx), 32'd0);
        chk("reseed_draw_time", 32'(at - tcyc), 32'd10);
        chk("reseed_draw_data", 32'(data), 32'h0B);
        req = 4'b0010;
        seeds = 0; found = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (lfsr_reset) seeds++;
            if (ack != 4'b0000) begin
                found = 1'b1; at = cyc; idx = int'(ack); data = rnd_data;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("reseed_next_seen", 32'(found), 32'd1);
        chk("reseed_next_ack", 32'(idx), 32'h2);
        chk("reseed_next_time", 32'(at - tcyc), 32'd30);
        chk("reseed_seed_len_ge8", 32'(seeds >= 8), 32'd1);
        chk("reseed_next_data", 32'(data), 32'h0B);
        req = 4'b0000;

        // ---- reset asserted on the fourth STEP cycle
        @(posedge clk); #1;
        wait_idle(20, ok);
        chk("rst_idle_seen", 32'(ok), 32'd1);
        req = 4'b0001;
        repeat (4) begin @(posedge clk); #1; end
        chk("rst_step4_enable", 32'(lfsr_enable), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req = 4'b0000;
        chk("rst_after_ack", 32'(ack), 32'd0);
        chk("rst_after_enable", 32'(lfsr_enable), 32'd0);
        chk("rst_after_busy", 32'(busy), 32'd1);
        chk("rst_after_lfsr_reset", 32'(lfsr_reset), 32'd1);
        n_ack = 0;
        repeat (30) begin
            @(negedge clk);
            if (ack != 4'b0000) n_ack++;
            @(posedge clk); #1;
        end
        chk("rst_dropped_no_ack", 32'(n_ack), 32'd0);

        // ---- stuck core: ready never rises
        stuck = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req = 4'b0001;
        n_bad = 0; n_ack = 0;
        repeat (100) begin
            @(negedge clk);
            if (!busy) n_bad++;
            if (ack != 4'b0000) n_ack++;
            @(posedge clk); #1;
        end
        chk("stuck_busy_low_cycles", 32'(n_bad), 32'd0);
        chk("stuck_acks", 32'(n_ack), 32'd0);
        chk("stuck_lfsr_reset", 32'(lfsr_reset), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_lfsr_share_ctrl

`default_nettype wire
